prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
- REQ-001: Parameter ADDR_W, 8, RAM address width; the RAM holds 2**ADDR_W words.
- REQ-002: Parameter DATA_W, 16, RAM word width.
- REQ-003: Port clk, input, 1, the single clock; all state updates on its rising edge.
- REQ-004: Port rst, input, 1, synchronous active-high reset.
- REQ-005: Port in_valid, input, 1, an upstream program word is present.
- REQ-006: Port in_ready, output, 1, the loader accepts a word this cycle; a handshake is in_valid&&in_ready at a rising edge.
- REQ-007: Port in_data, input, DATA_W, the program word.
- REQ-008: Port in_last, input, 1, marks the final word of the stream.
- REQ-009: Port mem_we, output, 1, RAM write enable, matching the we port of ram.
- REQ-010: Port mem_addr, output, ADDR_W, RAM address.
- REQ-011: Port mem_d, output, DATA_W, RAM write data.
- REQ-012: Port cpu_rst, output, 1, active-high reset driven to proj1; it holds the CPU in reset until the load completes.
- REQ-013: Port done, output, 1, the load completed successfully.
- REQ-014: Port err, output, 1, the load failed.
- REQ-015: Port word_cnt, output, ADDR_W+1, count of words written to RAM.

Function
- REQ-016: FSM states are LOAD, RUN and ERROR, plus CHECK when PROG_LOADER_CHECKSUM_EN is defined.
- REQ-017: In LOAD, in_ready=1; in RUN, ERROR and CHECK, in_ready=0, and in_valid is ignored.
- REQ-018: Write latency: for a data-word handshake at edge N, mem_we=1 with mem_addr=word_cnt and mem_d=in_data during cycle N+1 only; the word is written at edge N+1.
- REQ-019: mem_we is 0 in every other cycle; there are no duplicate writes when in_valid stays high across gaps or stalls.
- REQ-020: word_cnt increments by 1 with each write; the address is word_cnt[ADDR_W-1:0].
- REQ-021: After the last-word handshake at edge N, the FSM enters RUN at edge N+2; cpu_rst=0 and done=1 from cycle N+2 onward.
- REQ-022: A single-word stream (in_last on the first word) is legal and writes address 0.
- REQ-023: Full: a word with in_last at word_cnt==2**ADDR_W-1 is legal and writes the top address.
- REQ-024: Overflow: a handshake at word_cnt==2**ADDR_W is accepted but not written; the FSM enters ERROR at the next edge with err=1, and the address never wraps.
- REQ-025: RUN and ERROR are terminal until rst.
- REQ-026: In ERROR, cpu_rst=1 and done=0.

Reset
- REQ-027: While rst=1 at an edge, the block enters LOAD with word_cnt=0, mem_we=0, mem_addr=0, mem_d=0, cpu_rst=1, done=0 and err=0.
- REQ-028: An rst applied mid-load aborts the load, discards any pending write and restarts at address 0; RAM contents already written are not cleared.

Configuration
- REQ-029: When PROG_LOADER_CHECKSUM_EN is defined, the in_last word is a checksum and is not written to RAM.
  - A running sum modulo 2**DATA_W of the written words is compared with it in CHECK, which occupies the cycle after the handshake.
  - On a match the FSM enters RUN; on a mismatch it enters ERROR.
  - Total latency from the last handshake is unchanged at N+2.
  - A checksum-only stream with value 0 enters RUN with word_cnt=0.
  - A checksum arriving at word_cnt==2**ADDR_W is legal.
- REQ-030: When PROG_LOADER_CHECKSUM_EN is not defined, there is no CHECK state and no adder, and the in_last word is data.

Structure
- REQ-031: ADDR_W, DATA_W and the state enumeration live in the shared package cpu_pkg.
- REQ-032: The checksum accumulator is a separate sub-module, prog_chk_acc, instantiated only under PROG_LOADER_CHECKSUM_EN; the loader is otherwise flat.

Verification
- REQ-033: Basic load. After rst, stream 0x1234, 0x0001, 0xBEEF(last) -> RAM[0..2] hold these values; cpu_rst falls 2 cycles after the last handshake; word_cnt=3; done=1.
- REQ-034: Gapped valid. in_valid toggles 1,0,1 with data held between handshakes -> exactly one write per handshake.
- REQ-035: Full and overflow.
  - 256 words, last on the 256th -> RAM[0xFF] written, RUN.
  - 257 words with no last -> err=1 one cycle after the 257th handshake; RAM[0] unchanged.
- REQ-036: Reset mid-load. Assert rst after 5 words -> in_ready=1 and word_cnt=0; the next word is written to address 0.
- REQ-037: Checksum, with PROG_LOADER_CHECKSUM_EN defined.
  - 0x0001, 0x0002, 0x0003(last) -> RUN with 2 writes.
  - The same stream with 0x0004 as last -> ERROR; cpu_rst stays 1.
- REQ-038: Terminal state. Drive in_valid=1 in RUN -> in_ready=0 and mem_we stays 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared widths and loader FSM state encoding for the CPU program-load path.
package cpu_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_LOAD  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_ERROR = 2'd2;
  localparam state_t ST_CHECK = 2'd3;

endpackage

// File: rtl/prog_chk_acc.sv
// Running modulo-2**DATA_W sum of the program words written to RAM.
module prog_chk_acc #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              add_en,
  input  logic [DATA_W-1:0] add_data,
  output logic [DATA_W-1:0] sum
);

  logic [DATA_W-1:0] sum_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
    end else if (add_en) begin
      sum_q <= sum_q + add_data;
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/prog_loader.sv
// Streams a program into RAM and holds the CPU in reset until the load completes.
// Optional trailing-checksum verification is enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = cpu_pkg::ADDR_W,
  parameter int unsigned DATA_W = cpu_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_d,
  output logic              cpu_rst,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_cnt
);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
  logic [ADDR_W:0]   cnt_eff;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_d_q, mem_d_d;
  logic              hs;
  logic              full;

  // Count including the write still in flight, so back-to-back words get consecutive addresses.
  assign cnt_eff = word_cnt_q + (ADDR_W + 1)'(mem_we_q);
  assign full    = cnt_eff[ADDR_W];
  assign hs      = in_valid && in_ready;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] chk_q;
  logic [DATA_W-1:0] sum;

  prog_chk_acc #(
    .DATA_W (DATA_W)
  ) u_chk_acc (
    .clk      (clk),
    .rst      (rst),
    .add_en   (hs && !in_last && !full),
    .add_data (in_data),
    .sum      (sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      chk_q <= '0;
    end else if (hs && in_last) begin
      chk_q <= in_data;
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    word_cnt_d = cnt_eff;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_d_d    = mem_d_q;
    case (state_q)
      ST_LOAD: begin
        if (hs) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          if (in_last) begin
            state_d = ST_CHECK;
          end else if (full) begin
            state_d = ST_ERROR;
          end else begin
            mem_we_d   = 1'b1;
            mem_addr_d = cnt_eff[ADDR_W-1:0];
            mem_d_d    = in_data;
          end
`else
          if (full) begin
            state_d = ST_ERROR;
          end else begin
            mem_we_d   = 1'b1;
            mem_addr_d = cnt_eff[ADDR_W-1:0];
            mem_d_d    = in_data;
            if (in_last) begin
              state_d = ST_RUN;
            end
          end
`endif
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      ST_CHECK: state_d = (sum == chk_q) ? ST_RUN : ST_ERROR;
`endif
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_LOAD;
      word_cnt_q <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_d_q    <= '0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_d_q    <= mem_d_d;
    end
  end

  assign in_ready = (state_q == ST_LOAD);
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_d    = mem_d_q;
  assign word_cnt = word_cnt_q;
  // Release the CPU only once the final RAM write has landed.
  assign done     = (state_q == ST_RUN) && !mem_we_q;
  assign cpu_rst  = !done;
  assign err      = (state_q == ST_ERROR);

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with a write scoreboard and a behavioural RAM.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_d;
  logic        cpu_rst;
  logic        done;
  logic        err;
  logic [8:0]  word_cnt;

  int          checks = 0;
  int          errors = 0;
  int          exp_cnt = 0;
  logic [23:0] sb[$];
  logic [23:0] sb_e;
  logic [15:0] ram[256];

  always #5 clk = ~clk;

  prog_loader dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_d    (mem_d),
    .cpu_rst  (cpu_rst),
    .done     (done),
    .err      (err),
    .word_cnt (word_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Writes are taken by the RAM at the edge closing a cycle with mem_we high.
  always @(negedge clk) begin
    if (!rst && mem_we) begin
      if (sb.size() == 0) begin
        check("unexpected_write", 32'(mem_we), 0);
      end else begin
        sb_e = sb.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(sb_e[23:16]));
        check("wr_data", 32'(mem_d), 32'(sb_e[15:0]));
      end
      ram[mem_addr] = mem_d;
    end
  end

  task automatic send(input logic [15:0] d, input logic last, input logic wr);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("hs_ready_timeout", 32'(in_ready), 1);
      in_valid = 1'b0;
      return;
    end
    if (wr) begin
      sb.push_back({8'(exp_cnt), d});
      exp_cnt++;
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    exp_cnt = 0;
  endtask

  initial begin
    do_reset();
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_word_cnt", 32'(word_cnt), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_d", 32'(mem_d), 0);
    check("rst_cpu_rst", 32'(cpu_rst), 1);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);

`ifdef PROG_LOADER_CHECKSUM_EN
    // Checksum mismatch: 1 + 2 != 4.
    send(16'h0001, 1'b0, 1'b1);
    send(16'h0002, 1'b0, 1'b1);
    send(16'h0004, 1'b1, 1'b0);
    idle(1);
    check("bad_chk_cyc1_cpu_rst", 32'(cpu_rst), 1);
    idle(1);
    check("bad_chk_err", 32'(err), 1);
    check("bad_chk_cpu_rst", 32'(cpu_rst), 1);
    check("bad_chk_done", 32'(done), 0);

    do_reset();
    send(16'h0001, 1'b0, 1'b1);
    send(16'h0002, 1'b0, 1'b1);
    send(16'h0003, 1'b1, 1'b0);
    idle(1);
    check("chk_cyc1_done", 32'(done), 0);
    idle(1);
    check("chk_done", 32'(done), 1);
    check("chk_cpu_rst", 32'(cpu_rst), 0);
    check("chk_word_cnt", 32'(word_cnt), 2);
    check("chk_sb_empty", 32'(sb.size()), 0);
`else
    // Basic three-word load.
    send(16'h1234, 1'b0, 1'b1);
    send(16'h0001, 1'b0, 1'b1);
    send(16'hBEEF, 1'b1, 1'b1);
    idle(1);
    check("basic_cyc1_mem_we", 32'(mem_we), 1);
    check("basic_cyc1_cpu_rst", 32'(cpu_rst), 1);
    check("basic_cyc1_in_ready", 32'(in_ready), 0);
    idle(1);
    check("basic_cpu_rst", 32'(cpu_rst), 0);
    check("basic_done", 32'(done), 1);
    check("basic_word_cnt", 32'(word_cnt), 3);
    check("basic_ram0", 32'(ram[0]), 32'h1234);
    check("basic_ram1", 32'(ram[1]), 32'h0001);
    check("basic_ram2", 32'(ram[2]), 32'hBEEF);
`endif

    // RUN is terminal: no further handshakes or writes.
    @(negedge clk);
    in_valid = 1'b1;
    in_last  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("run_in_ready", 32'(in_ready), 0);
      check("run_mem_we", 32'(mem_we), 0);
    end
    check("run_done_held", 32'(done), 1);
    idle(1);

`ifndef PROG_LOADER_CHECKSUM_EN
    // Gapped valid with data held across the gap.
    do_reset();
    send(16'hA001, 1'b0, 1'b1);
    idle(1);
    send(16'hA002, 1'b0, 1'b1);
    idle(2);
    send(16'hA003, 1'b1, 1'b1);
    idle(3);
    check("gap_word_cnt", 32'(word_cnt), 3);
    check("gap_sb_empty", 32'(sb.size()), 0);
    check("gap_done", 32'(done), 1);

    // Fill every address, last word on the top one.
    do_reset();
    for (int i = 0; i < 256; i++) send(16'(16'h5000 + i), (i == 255), 1'b1);
    idle(1);
    check("full_cyc1_done", 32'(done), 0);
    idle(1);
    check("full_done", 32'(done), 1);
    check("full_word_cnt", 32'(word_cnt), 256);
    check("full_ram_top", 32'(ram[255]), 32'h50FF);
    check("full_err", 32'(err), 0);

    // Overflow: 257th word accepted but never written.
    do_reset();
    for (int i = 0; i < 256; i++) send(16'(16'h1000 + i), 1'b0, 1'b1);
    send(16'hDEAD, 1'b0, 1'b0);
    idle(1);
    check("ovf_err", 32'(err), 1);
    check("ovf_mem_we", 32'(mem_we), 0);
    check("ovf_cpu_rst", 32'(cpu_rst), 1);
    check("ovf_done", 32'(done), 0);
    idle(2);
    check("ovf_ram0", 32'(ram[0]), 32'h1000);
    check("ovf_word_cnt", 32'(word_cnt), 256);
    check("ovf_sb_empty", 32'(sb.size()), 0);
    check("ovf_err_held", 32'(err), 1);
`endif

    // Reset in the middle of a load restarts at address 0.
    do_reset();
    for (int i = 0; i < 5; i++) send(16'(16'h0C00 + i), 1'b0, 1'b1);
    idle(2);
    check("mid_pre_word_cnt", 32'(word_cnt), 5);
    do_reset();
    check("mid_in_ready", 32'(in_ready), 1);
    check("mid_word_cnt", 32'(word_cnt), 0);
    send(16'h7777, 1'b0, 1'b1);
    idle(2);
    check("mid_ram0", 32'(ram[0]), 32'h7777);
    check("mid_ram1_kept", 32'(ram[1]), 32'h0C01);
    check("mid_word_cnt_after", 32'(word_cnt), 1);
    check("mid_sb_empty", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
